// File: rtl/wb_spi_slave_pkg.sv
// Shared definitions for the Wishbone SPI target: register map, STATUS/CTRL bit
// positions and the transfer FSM state encoding.
package wb_spi_slave_pkg;

  // Register offsets, decoded from wb_adr_i[3:2]
  localparam logic [1:0] RegRxdata = 2'd0;
  localparam logic [1:0] RegTxdata = 2'd1;
  localparam logic [1:0] RegStatus = 2'd2;
  localparam logic [1:0] RegCtrl   = 2'd3;

  // STATUS bit indices
  localparam int unsigned StatRxAvail  = 0;
  localparam int unsigned StatRxFull   = 1;
  localparam int unsigned StatTxFull   = 2;
  localparam int unsigned StatOverrun  = 3;
  localparam int unsigned StatUnderrun = 4;
  localparam int unsigned StatBusy     = 5;
  localparam int unsigned StatCsActive = 6;

  // CTRL bit indices
  localparam int unsigned CtrlIeRx    = 0;
  localparam int unsigned CtrlIeTx    = 1;
  localparam int unsigned CtrlIeErr   = 2;
  localparam int unsigned CtrlClrOvr  = 8;
  localparam int unsigned CtrlClrUnd  = 9;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StShift = 2'd2
  } spi_state_e;

endpackage

// File: rtl/wb_spi_slave_if.sv
// Wishbone classic bus bundle between a bus master (conbus) and the SPI target.
// Signal names are from the target's point of view (_i = into the target).
//   wb_adr_i  byte address, wb_dat_i write data, wb_dat_o read data,
//   wb_stb_i/wb_cyc_i strobe/cycle, wb_we_i write enable, wb_sel_i byte lanes,
//   wb_ack_o one-cycle acknowledge.
interface wb_spi_slave_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/spi_rx_fifo.sv
// Synchronous receive FIFO for bytes collected from the SPI master.
//   clk_i/rst_ni  clock, async active-low reset
//   push_i/data_i write request and data; accepted when not full, or when a pop
//                 in the same cycle frees a slot
//   pop_i         drop the head entry (ignored when empty)
//   data_o        current head entry
//   full_o/empty_o/count_o occupancy
module spi_rx_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [Width-1:0]           data_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     count_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = AddrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DepthCnt);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Power-of-two depth: pointer overflow is the modulo wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/wb_spi_slave.sv
// Wishbone-attached SPI target, mode 0, 8-bit frames, MSB first. All SPI pins are
// oversampled in the clk domain (f_clk >= 8 x f_sck).
//   clk, rst      system clock, async active-low reset
//   wb            Wishbone slave port (RXDATA, TXDATA, STATUS, CTRL at adr[3:2])
//   intr          level interrupt from rx_avail / tx empty / error flags
//   spi_sck, spi_cs_n, spi_mosi  pins from the external master
//   spi_miso, spi_miso_oe        slave data out and its pad enable
module wb_spi_slave
  import wb_spi_slave_pkg::*;
#(
  parameter int unsigned rx_depth  = 4,
  parameter logic [7:0]  idle_fill = 8'hFF
) (
  input  logic                 clk,
  input  logic                 rst,
  wb_spi_slave_if.slave        wb,
  output logic                 intr,
  input  logic                 spi_sck,
  input  logic                 spi_cs_n,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic                 spi_miso_oe
);

  // ---------------------------------------------------------------------------
  // Pin synchronizers and edge detectors
  // ---------------------------------------------------------------------------
  logic [1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic       sck_prev_q, cs_prev_q;
  logic       sck_s, cs_s, mosi_s;
  logic       sck_rise, sck_fall, cs_fall;

  // cs stages reset high so releasing reset never looks like a select.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_sync_q  <= 2'b00;
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b00;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[0], spi_sck};
      cs_sync_q   <= {cs_sync_q[0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
      sck_prev_q  <= sck_sync_q[1];
      cs_prev_q   <= cs_sync_q[1];
    end
  end

  assign sck_s    = sck_sync_q[1];
  assign cs_s     = cs_sync_q[1];
  assign mosi_s   = mosi_sync_q[1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_fall  = cs_prev_q & ~cs_s;

  // ---------------------------------------------------------------------------
  // Register state
  // ---------------------------------------------------------------------------
  spi_state_e  state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  tx_hold_q, tx_hold_d;
  logic        tx_full_q, tx_full_d;
  logic        overrun_q, overrun_d;
  logic        underrun_q, underrun_d;
  logic [2:0]  ie_q, ie_d;
  logic        ack_q;
  logic [31:0] dat_q, dat_d;

  logic        load;
  logic        push;
  logic [7:0]  push_data;

  logic        fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_head;
  logic [$clog2(rx_depth):0] fifo_count;

  // ---------------------------------------------------------------------------
  // Transfer FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    load       = 1'b0;
    push       = 1'b0;
    push_data  = {rx_shift_q[6:0], mosi_s};

    unique case (state_q)
      StIdle: begin
        if (cs_fall) state_d = StLoad;
      end
      StLoad: begin
        load      = 1'b1;
        bit_cnt_d = 4'd0;
        state_d   = cs_s ? StIdle : StShift;
      end
      StShift: begin
        // A rise coinciding with cs release is still processed so a completed
        // byte is pushed before returning to idle.
        if (sck_rise) begin
          rx_shift_d = push_data;
          bit_cnt_d  = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) push = 1'b1;
        end else if (sck_fall && !cs_s) begin
          if (bit_cnt_q == 4'd8) begin
            // Byte boundary: prepare the next byte for back-to-back transfers.
            load      = 1'b1;
            bit_cnt_d = 4'd0;
          end else if (bit_cnt_q != 4'd0) begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end
        if (cs_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (load) tx_shift_d = tx_full_q ? tx_hold_q : idle_fill;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      bit_cnt_q  <= 4'd0;
      tx_shift_q <= 8'hFF;
      rx_shift_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  assign spi_miso_oe = (state_q == StShift);
  assign spi_miso    = spi_miso_oe ? tx_shift_q[7] : 1'b1;

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  spi_rx_fifo #(
    .Depth (rx_depth),
    .Width (8)
  ) u_rx_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // ---------------------------------------------------------------------------
  // Wishbone register block
  // ---------------------------------------------------------------------------
  logic        wb_req;
  logic [1:0]  reg_sel;
  logic        wr_tx, wr_ctrl, rd_rx;
  logic [31:0] status_word, rdata;

  assign wb_req   = wb.wb_stb_i & wb.wb_cyc_i & ~ack_q;
  assign reg_sel  = wb.wb_adr_i[3:2];
  assign wr_tx    = wb_req & wb.wb_we_i & (reg_sel == RegTxdata);
  assign wr_ctrl  = wb_req & wb.wb_we_i & (reg_sel == RegCtrl);
  assign rd_rx    = wb_req & ~wb.wb_we_i & (reg_sel == RegRxdata);
  assign fifo_pop = rd_rx & ~fifo_empty;

  always_comb begin
    status_word               = '0;
    status_word[StatRxAvail]  = ~fifo_empty;
    status_word[StatRxFull]   = fifo_full;
    status_word[StatTxFull]   = tx_full_q;
    status_word[StatOverrun]  = overrun_q;
    status_word[StatUnderrun] = underrun_q;
    status_word[StatBusy]     = (state_q != StIdle);
    status_word[StatCsActive] = ~cs_s;
  end

  always_comb begin
    rdata = '0;
    unique case (reg_sel)
      RegRxdata: rdata = fifo_empty ? 32'd0 : {24'd0, fifo_head};
      RegTxdata: rdata = '0;
      RegStatus: rdata = status_word;
      RegCtrl:   rdata = {29'd0, ie_q};
      default:   rdata = '0;
    endcase
    dat_d = (wb_req && !wb.wb_we_i) ? rdata : 32'd0;
  end

  // Clears are applied before sets so a flag event in the same cycle as a
  // software clear is not lost; a TXDATA write lands after the FSM has taken
  // the previous holding value.
  always_comb begin
    tx_hold_d  = tx_hold_q;
    tx_full_d  = tx_full_q;
    overrun_d  = overrun_q;
    underrun_d = underrun_q;
    ie_d       = ie_q;

    if (wr_ctrl) begin
      ie_d = wb.wb_dat_i[2:0];
      if (wb.wb_dat_i[CtrlClrOvr]) overrun_d  = 1'b0;
      if (wb.wb_dat_i[CtrlClrUnd]) underrun_d = 1'b0;
    end

    if (load) begin
      if (tx_full_q) tx_full_d  = 1'b0;
      else           underrun_d = 1'b1;
    end

    if (push && fifo_full && !fifo_pop) overrun_d = 1'b1;

    if (wr_tx) begin
      tx_hold_d = wb.wb_dat_i[7:0];
      tx_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_hold_q  <= 8'h00;
      tx_full_q  <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
      ie_q       <= 3'b000;
      ack_q      <= 1'b0;
      dat_q      <= 32'd0;
    end else begin
      tx_hold_q  <= tx_hold_d;
      tx_full_q  <= tx_full_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
      ie_q       <= ie_d;
      ack_q      <= wb_req;
      dat_q      <= dat_d;
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;

  assign intr = (ie_q[CtrlIeRx] & ~fifo_empty) |
                (ie_q[CtrlIeTx] & ~tx_full_q) |
                (ie_q[CtrlIeErr] & (overrun_q | underrun_q));

  // Address/data bits outside the decoded fields and the byte lanes.
  logic unused_bits;
  assign unused_bits = ^{wb.wb_adr_i[31:4], wb.wb_adr_i[1:0], wb.wb_dat_i[31:10],
                         wb.wb_sel_i, fifo_count};

endmodule

// File: tb/tb_wb_spi_slave.sv
// Bench for wb_spi_slave: drives Wishbone and an SPI master (mode 0) and checks
// against a queue-based model of the register block.
module tb_wb_spi_slave;
  import wb_spi_slave_pkg::*;

  localparam int unsigned Depth = 4;
  localparam int unsigned Half  = 8;   // clk cycles per sck half period

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic intr;
  logic sck = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic miso, miso_oe;

  wb_spi_slave_if wb ();

  wb_spi_slave #(
    .rx_depth  (Depth),
    .idle_fill (8'hFF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wb          (wb),
    .intr        (intr),
    .spi_sck     (sck),
    .spi_cs_n    (cs_n),
    .spi_mosi    (mosi),
    .spi_miso    (miso),
    .spi_miso_oe (miso_oe)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model
  logic [7:0] m_fifo [$];
  logic [7:0] m_hold;
  logic       m_full, m_ovr, m_und;
  logic [2:0] m_ie;

  task automatic model_reset();
    m_fifo.delete();
    m_hold = 8'h00;
    m_full = 1'b0;
    m_ovr  = 1'b0;
    m_und  = 1'b0;
    m_ie   = 3'b000;
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = 32'd0;
    s[0] = (m_fifo.size() != 0);
    s[1] = (m_fifo.size() == Depth);
    s[2] = m_full;
    s[3] = m_ovr;
    s[4] = m_und;
    return s;
  endfunction

  function automatic logic model_intr();
    return (m_ie[0] && m_fifo.size() != 0) || (m_ie[1] && !m_full) || (m_ie[2] && (m_ovr || m_und));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One Wishbone access with ack timing checks.
  task automatic wb_access(input logic we, input logic [1:0] idx, input logic [31:0] wdata,
                           output logic [31:0] rdata);
    @(posedge clk); #1;
    wb.wb_adr_i = {28'd0, idx, 2'b00};
    wb.wb_dat_i = wdata;
    wb.wb_we_i  = we;
    wb.wb_sel_i = 4'hF;
    wb.wb_stb_i = 1'b1;
    wb.wb_cyc_i = 1'b1;
    check("ack_before", wb.wb_ack_o, 0);
    @(posedge clk); #1;
    check("ack_pulse", wb.wb_ack_o, 1);
    rdata = wb.wb_dat_o;
    wb.wb_stb_i = 1'b0;
    wb.wb_cyc_i = 1'b0;
    wb.wb_we_i  = 1'b0;
    @(posedge clk); #1;
    check("ack_after", wb.wb_ack_o, 0);
  endtask

  task automatic reg_write(input logic [1:0] idx, input logic [31:0] d);
    logic [31:0] r;
    wb_access(1'b1, idx, d, r);
    if (idx == RegTxdata) begin
      m_hold = d[7:0];
      m_full = 1'b1;
    end else if (idx == RegCtrl) begin
      m_ie = d[2:0];
      if (d[8]) m_ovr = 1'b0;
      if (d[9]) m_und = 1'b0;
    end
  endtask

  task automatic reg_read_check(input logic [1:0] idx, input string tag);
    logic [31:0] exp, r;
    unique case (idx)
      RegRxdata: exp = (m_fifo.size() != 0) ? {24'd0, m_fifo.pop_front()} : 32'd0;
      RegTxdata: exp = 32'd0;
      RegStatus: exp = model_status();
      default:   exp = {29'd0, m_ie};
    endcase
    wb_access(1'b0, idx, 32'd0, r);
    check(tag, r, exp);
  endtask

  // Byte handed to MISO at a byte start, and its effect on the flags.
  task automatic model_load(output logic [7:0] exp);
    exp = m_full ? m_hold : 8'hFF;
    if (m_full) m_full = 1'b0;
    else        m_und  = 1'b1;
  endtask

  task automatic model_push(input logic [7:0] b);
    if (m_fifo.size() < Depth) m_fifo.push_back(b);
    else                       m_ovr = 1'b1;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Full frame of n bytes under one cs assertion. cs is released while sck is
  // still high after the last rise, then sck returns low.
  task automatic spi_frame(input int n, input logic [7:0] d [8]);
    logic [7:0] exp, got;
    @(posedge clk); #1;
    check("oe_idle", miso_oe, 0);
    check("miso_idle", miso, 1);
    cs_n = 1'b0;
    for (int b = 0; b < n; b++) begin
      model_load(exp);
      got = 8'h00;
      for (int i = 7; i >= 0; i--) begin
        mosi = d[b][i];
        wait_clk(Half);
        if (i == 7) check("oe_active", miso_oe, 1);
        got[i] = miso;
        sck = 1'b1;
        wait_clk(Half);
        if (!(b == n - 1 && i == 0)) sck = 1'b0;
      end
      check("miso_byte", got, exp);
      model_push(d[b]);
    end
    cs_n = 1'b1;
    wait_clk(4);
    check("oe_drop", miso_oe, 0);
    wait_clk(Half);
    sck = 1'b0;
    wait_clk(Half);
  endtask

  // cs released after nbits rises: the partial byte must vanish.
  task automatic spi_partial(input int nbits, input logic [7:0] d);
    logic [7:0] exp, got;
    @(posedge clk); #1;
    cs_n = 1'b0;
    model_load(exp);
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = d[7 - i];
      wait_clk(Half);
      got[7 - i] = miso;
      sck = 1'b1;
      wait_clk(Half);
      if (i != nbits - 1) sck = 1'b0;
    end
    check("miso_partial", {24'd0, got >> (8 - nbits)}, {24'd0, exp >> (8 - nbits)});
    cs_n = 1'b1;
    wait_clk(4);
    check("oe_drop_partial", miso_oe, 0);
    wait_clk(Half);
    sck = 1'b0;
    wait_clk(Half);
  endtask

  initial begin
    logic [7:0] d [8];
    int         n;
    int         cnt;

    wb.wb_adr_i = 32'd0;
    wb.wb_dat_i = 32'd0;
    wb.wb_we_i  = 1'b0;
    wb.wb_sel_i = 4'h0;
    wb.wb_stb_i = 1'b0;
    wb.wb_cyc_i = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) d[i] = 8'h00;

    // Reset values
    wait_clk(3);
    check("rst_oe", miso_oe, 0);
    check("rst_miso", miso, 1);
    check("rst_intr", intr, 0);
    check("rst_ack", wb.wb_ack_o, 0);
    check("rst_dat", wb.wb_dat_o, 0);
    rst = 1'b1;
    wait_clk(2);
    reg_read_check(RegStatus, "status_reset");
    check("intr_reset", intr, 0);

    // Single byte with a loaded holding register
    reg_write(RegTxdata, 32'h0000_00A5);
    d[0] = 8'h3C;
    spi_frame(1, d);
    reg_read_check(RegStatus, "status_one_byte");
    reg_read_check(RegRxdata, "rx_one_byte");
    reg_read_check(RegStatus, "status_drained");
    reg_read_check(RegTxdata, "txdata_reads_zero");

    // Three bytes, holding empty: idle fill and underrun
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
    spi_frame(3, d);
    reg_read_check(RegStatus, "status_underrun");
    for (int i = 0; i < 3; i++) reg_read_check(RegRxdata, "rx_three");
    reg_read_check(RegRxdata, "rx_empty_read");
    reg_write(RegCtrl, 32'h0000_0200);
    reg_read_check(RegStatus, "status_und_clear");

    // Overrun: five bytes into a four-entry FIFO
    for (int i = 0; i < 5; i++) d[i] = 8'(8'h40 + i);
    spi_frame(5, d);
    reg_read_check(RegStatus, "status_overrun");
    reg_write(RegCtrl, 32'h0000_0100);
    reg_read_check(RegStatus, "status_ovr_clear");
    for (int i = 0; i < 4; i++) reg_read_check(RegRxdata, "rx_overrun");
    reg_write(RegCtrl, 32'h0000_0200);
    reg_read_check(RegStatus, "status_after_ovr");

    // Partial byte, then a clean byte
    reg_write(RegTxdata, 32'h0000_005A);
    spi_partial(5, 8'($urandom));
    reg_read_check(RegStatus, "status_partial");
    d[0] = 8'($urandom);
    spi_frame(1, d);
    reg_read_check(RegRxdata, "rx_after_partial");
    reg_write(RegCtrl, 32'h0000_0300);

    // Interrupt enables
    reg_write(RegCtrl, 32'h0000_0001);
    check("intr_rx_off", intr, model_intr());
    d[0] = 8'hC3;
    spi_frame(1, d);
    check("intr_rx_on", intr, model_intr());
    reg_read_check(RegRxdata, "rx_intr");
    check("intr_rx_clear", intr, model_intr());
    reg_write(RegCtrl, 32'h0000_0002);
    check("intr_tx_empty", intr, model_intr());
    reg_write(RegTxdata, 32'h0000_0077);
    check("intr_tx_full", intr, model_intr());
    reg_read_check(RegCtrl, "ctrl_readback");
    spi_frame(1, d);
    check("intr_tx_consumed", intr, model_intr());
    reg_write(RegCtrl, 32'h0000_0304);
    check("intr_err_off", intr, model_intr());
    reg_read_check(RegRxdata, "rx_drain");

    // Asynchronous reset in the middle of a frame
    reg_write(RegTxdata, 32'h0000_0081);
    @(posedge clk); #1;
    cs_n = 1'b0;
    wait_clk(Half);
    sck = 1'b1;
    wait_clk(3);
    check("pre_rst_oe", miso_oe, 1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_oe", miso_oe, 0);
    check("async_rst_miso", miso, 1);
    check("async_rst_intr", intr, 0);
    model_reset();
    cs_n = 1'b1;
    sck  = 1'b0;
    wait_clk(2);
    rst = 1'b1;
    wait_clk(2);
    reg_read_check(RegStatus, "status_after_async_rst");

    // Randomized frames
    for (int it = 0; it < 8; it++) begin
      reg_write(RegCtrl, {22'd0, 2'b00, 5'd0, 3'($urandom)});
      if ($urandom_range(0, 1) == 1) reg_write(RegTxdata, {24'd0, 8'($urandom)});
      if ($urandom_range(0, 3) == 0) reg_write(RegTxdata, {24'd0, 8'($urandom)});
      n = $urandom_range(1, 6);
      for (int i = 0; i < 8; i++) d[i] = 8'($urandom);
      spi_frame(n, d);
      reg_read_check(RegStatus, "rand_status");
      check("rand_intr", intr, model_intr());
      cnt = m_fifo.size();
      for (int i = 0; i <= cnt; i++) reg_read_check(RegRxdata, "rand_rx");
      reg_write(RegCtrl, {22'd0, 2'b11, 5'd0, m_ie});
      check("rand_intr_clr", intr, model_intr());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
